// File: rtl/wb_uart_host.sv
// Wishbone initiator for the UART CSR slave.
// Single read/write plus poll-until-clear with ack timeout.
module wb_uart_host #(
  parameter int TIMEOUT  = 255,
  parameter int POLL_MAX = 1023,
  parameter int POLL_GAP = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_poll,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_dat,
  input  logic [3:0]  req_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int IW = $clog2(POLL_MAX + 1);
  localparam int GW = $clog2(POLL_GAP + 1);

  typedef enum logic [1:0] {
    IDLE, BUS, GAP, RESP
  } state_e;

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic          poll_q, poll_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [3:0]    sel_q, sel_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [IW-1:0] iter_q, iter_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [31:0]   rdat_q, rdat_d;
  logic          rerr_q, rerr_d;
  logic [TW-1:0] tmo_inc;
  logic [IW-1:0] iter_inc;

  assign tmo_inc  = tmo_q + TW'(1);
  assign iter_inc = iter_q + IW'(1);

  // Bus outputs are decoded from state; attributes come from the latched command.
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_dat   = rdat_q;
  assign rsp_err   = rerr_q;
  assign wbm_cyc_o = (state_q == BUS);
  assign wbm_stb_o = (state_q == BUS);
  assign wbm_we_o  = we_q & (state_q == BUS);
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

  // Next-state, command latch, timeout/poll/gap counters and response capture.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    poll_d  = poll_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    tmo_d   = tmo_q;
    iter_d  = iter_q;
    gap_d   = gap_q;
    rdat_d  = rdat_q;
    rerr_d  = rerr_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          poll_d  = req_poll & ~req_we;
          adr_d   = req_adr;
          dat_d   = req_dat;
          sel_d   = req_sel;
          tmo_d   = '0;
          iter_d  = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        if (wbm_ack_i) begin
          tmo_d = '0;
          if (!poll_q) begin
            state_d = RESP;
            rerr_d  = 1'b0;
            rdat_d  = we_q ? 32'h0 : wbm_dat_i;
          end else if ((wbm_dat_i & dat_q) == 32'h0) begin
            state_d = RESP;
            rerr_d  = 1'b0;
            rdat_d  = wbm_dat_i;
          end else if (iter_inc == IW'(POLL_MAX)) begin
            state_d = RESP;
            rerr_d  = 1'b1;
            rdat_d  = wbm_dat_i;
          end else begin
            iter_d  = iter_inc;
            gap_d   = '0;
            state_d = GAP;
          end
        end else if (tmo_inc == TW'(TIMEOUT)) begin
          tmo_d   = '0;
          state_d = RESP;
          rerr_d  = 1'b1;
          rdat_d  = 32'h0;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      GAP: begin
        if (gap_q == GW'(POLL_GAP - 1)) begin
          tmo_d   = '0;
          state_d = BUS;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      poll_q  <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      tmo_q   <= '0;
      iter_q  <= '0;
      gap_q   <= '0;
      rdat_q  <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      poll_q  <= poll_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      tmo_q   <= tmo_d;
      iter_q  <= iter_d;
      gap_q   <= gap_d;
      rdat_q  <= rdat_d;
      rerr_q  <= rerr_d;
    end
  end

endmodule
